program_loader_ram: RTL and testbench
=====================================

# program_loader_ram

Writable program store with a nibble-stream loader, the write-side counterpart of the CPU's fixed instruction ROM. An external source pushes 4-bit opcodes over a valid/ready stream into internal RAM while the CPU is held, then releases it. The CPU fetches through the same combinational address-in/opcode-out read port the ROM provides. Unwritten locations read as CLR (4'b0111), the NOP-equivalent.

## Interface
- ADDR_WIDTH, 8, program address width; depth = 2^ADDR_WIDTH nibbles
- FILL_OPCODE, 4'b0111, value swept into memory on clear and forced onto dataOut while held (CLR/NOP)

- clk  in  1  rising-edge clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- loadStart  in  1  single-cycle request to begin a new program load
- nibbleIn  in  4  opcode to write
- nibbleValid  in  1  nibbleIn valid
- loadLast  in  1  qualifies the current nibble as the final one of the program
- nibbleReady  out  1  loader accepts a nibble this cycle
- addressIn  in  ADDR_WIDTH  CPU fetch address
- dataOut  out  4  opcode at addressIn (combinational)
- cpuHold  out  1  high while the CPU must stay stalled/reset
- loadDone  out  1  one-cycle pulse when a load completes
- loadError  out  1  sticky: memory filled without loadLast
- loadCount  out  ADDR_WIDTH+1  nibbles accepted in current/last load

## Operation
- States: CLEAR, LOAD, RUN. Internal flag loadPending.
- CLEAR: clearPtr counts 0..2^ADDR_WIDTH-1, writing FILL_OPCODE to mem[clearPtr] once per cycle. After the last address, go to LOAD if loadPending, else RUN. Clear loadPending on exit to LOAD.
- RUN: cpuHold=0, nibbleReady=0, dataOut=mem[addressIn]. loadStart -> CLEAR with loadPending=1. Also clear loadCount and loadError.
- LOAD: nibbleReady=1. A nibble is accepted when nibbleValid && nibbleReady.
  - On accept: mem[wrPtr]=nibbleIn, wrPtr++, loadCount++.
  - Accepted with loadLast=1: go to RUN and pulse loadDone.
  - Accepted at wrPtr=2^ADDR_WIDTH-1 with loadLast=0: the nibble is written, loadError set, loadDone pulsed, go to RUN. No wrap-around.
- In CLEAR and LOAD: cpuHold=1 and dataOut=FILL_OPCODE regardless of addressIn, so the CPU sees only NOP.
- loadStart in LOAD: abandon the load, clear loadCount and loadError, go to CLEAR with loadPending=1. Nibbles already written are erased by the sweep.
- loadStart in CLEAR: sets loadPending; the sweep continues uninterrupted.
- loadStart and an accepted nibble in the same LOAD cycle: loadStart wins and the nibble is discarded. nibbleReady is combinationally deasserted when loadStart=1.
- wrPtr resets to 0 on entry to LOAD.

## Timing
- Reset values: state=CLEAR, clearPtr=0, wrPtr=0, loadPending=0, cpuHold=1, nibbleReady=0, loadDone=0, loadError=0, loadCount=0, dataOut=FILL_OPCODE.
- Memory contents are not reset directly; the post-reset CLEAR sweep initialises them.
- CLEAR lasts exactly 2^ADDR_WIDTH cycles. The first RUN/LOAD cycle follows the cycle that writes the last address.
- Writes are synchronous on the clk rising edge. A written location is visible on dataOut from the cycle after the write, once in RUN.
- The read port is purely combinational from addressIn and state (zero latency), matching the ROM.
- loadDone is asserted in the first RUN cycle after the final accept, for exactly one cycle. cpuHold falls in that same cycle.
- Reset asserted mid-CLEAR or mid-LOAD: all outputs take reset values immediately (async). A full sweep restarts on release, and no partial program survives.

## Test plan
- ADDR_WIDTH=4, release reset -> cpuHold=1 for 16 cycles then 0; addresses 0..15 all read 4'b0111; loadDone never pulses.
- loadStart, then after the 16-cycle clear send 0000,0001,1010,0010,1011,0010,1110,0010 with loadLast on the 8th -> one loadDone pulse; loadCount=8; addr0..7 read the sent values; addr8..15 read 0111.
- Same load with nibbleValid toggled 1/0 and idle gaps -> writes only on valid&ready; identical memory image; loadCount=8.
- Load 16 nibbles 0001 with loadLast never set -> after the 16th accept: RUN, loadError=1, loadCount=16, nibbleReady=0; a 17th nibble is not accepted; addr0..15 read 0001.
- Assert reset after 3 accepted nibbles -> outputs return to reset values at once; after release and 16 clear cycles, all addresses read 0111.
- In LOAD after 5 nibbles, pulse loadStart together with a valid nibble -> the nibble is discarded; loadCount=0; 16-cycle re-clear; a new 2-nibble load (1000,0010 with last) leaves addr0=1000, addr1=0010, others 0111.

Source files
------------

// File: rtl/program_loader_ram.sv
`default_nettype none
// ============================================================================
// Module      : program_loader_ram
// Description : Writable program store with a nibble-stream loader. Memory is
//               swept to FILL_OPCODE, optionally loaded over a valid/ready
//               stream while the CPU is held, then read combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader_ram #(
  parameter int          ADDR_WIDTH  = 8,
  parameter logic [3:0]  FILL_OPCODE = 4'b0111
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  loadStart,
  input  logic [3:0]            nibbleIn,
  input  logic                  nibbleValid,
  input  logic                  loadLast,
  output logic                  nibbleReady,
  input  logic [ADDR_WIDTH-1:0] addressIn,
  output logic [3:0]            dataOut,
  output logic                  cpuHold,
  output logic                  loadDone,
  output logic                  loadError,
  output logic [ADDR_WIDTH:0]   loadCount
);

  localparam int                    c_depth     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_last_addr = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] c_addr_one  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   c_cnt_one   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_clear_ptr;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic                  r_load_pending;
  logic                  r_cpu_hold;
  logic                  r_load_done;
  logic                  r_load_error;
  logic [ADDR_WIDTH:0]   r_load_count;

  logic [3:0]            r_mem [c_depth];

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [3:0]            w_wdata;

  // A pending loadStart takes priority over any nibble offered in the same cycle
  assign w_ready  = (r_state == ST_LOAD) && !loadStart;
  assign w_accept = w_ready && nibbleValid;

  // Select the single memory write source: clear sweep or accepted nibble
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_clear_ptr;
    w_wdata = FILL_OPCODE;
    if (r_state == ST_CLEAR) begin
      w_we = 1'b1;
    end else if (w_accept) begin
      w_we    = 1'b1;
      w_waddr = r_wr_ptr;
      w_wdata = nibbleIn;
    end
  end

  // Program memory: no reset, contents are initialised by the post-reset sweep
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Loader control: clear sweep, stream load and run phases
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_CLEAR;
      r_clear_ptr    <= '0;
      r_wr_ptr       <= '0;
      r_load_pending <= 1'b0;
      r_cpu_hold     <= 1'b1;
      r_load_done    <= 1'b0;
      r_load_error   <= 1'b0;
      r_load_count   <= '0;
    end else begin
      r_load_done <= 1'b0;
      case (r_state)
        ST_CLEAR: begin
          if (r_clear_ptr == c_last_addr) begin
            r_clear_ptr <= '0;
            if (r_load_pending || loadStart) begin
              r_state        <= ST_LOAD;
              r_load_pending <= 1'b0;
              r_wr_ptr       <= '0;
            end else begin
              r_state    <= ST_RUN;
              r_cpu_hold <= 1'b0;
            end
          end else begin
            r_clear_ptr <= r_clear_ptr + c_addr_one;
            if (loadStart) begin
              r_load_pending <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (loadStart) begin
            r_state        <= ST_CLEAR;
            r_clear_ptr    <= '0;
            r_load_pending <= 1'b1;
            r_load_count   <= '0;
            r_load_error   <= 1'b0;
          end else if (w_accept) begin
            r_wr_ptr     <= r_wr_ptr + c_addr_one;
            r_load_count <= r_load_count + c_cnt_one;
            if (loadLast) begin
              r_state     <= ST_RUN;
              r_cpu_hold  <= 1'b0;
              r_load_done <= 1'b1;
            end else if (r_wr_ptr == c_last_addr) begin
              // Memory full without a final nibble: stop, never wrap
              r_state      <= ST_RUN;
              r_cpu_hold   <= 1'b0;
              r_load_done  <= 1'b1;
              r_load_error <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (loadStart) begin
            r_state        <= ST_CLEAR;
            r_clear_ptr    <= '0;
            r_cpu_hold     <= 1'b1;
            r_load_pending <= 1'b1;
            r_load_count   <= '0;
            r_load_error   <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_CLEAR;
          r_clear_ptr <= '0;
          r_cpu_hold  <= 1'b1;
        end
      endcase
    end
  end

  // The CPU only ever sees NOP while the store is being rewritten
  assign dataOut     = (r_state == ST_RUN) ? r_mem[addressIn] : FILL_OPCODE;
  assign nibbleReady = w_ready;
  assign cpuHold     = r_cpu_hold;
  assign loadDone    = r_load_done;
  assign loadError   = r_load_error;
  assign loadCount   = r_load_count;

endmodule
`default_nettype wire

// File: tb/tb_program_loader_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader_ram
// Description : Self-checking bench for program_loader_ram (ADDR_WIDTH=4),
//               directed table sequences plus random traffic vs a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader_ram;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       loadStart = 1'b0;
  logic [3:0] nibbleIn = 4'h0;
  logic       nibbleValid = 1'b0;
  logic       loadLast = 1'b0;
  logic       nibbleReady;
  logic [3:0] addressIn = 4'h0;
  logic [3:0] dataOut;
  logic       cpuHold;
  logic       loadDone;
  logic       loadError;
  logic [4:0] loadCount;

  int checks = 0;
  int failures = 0;

  program_loader_ram #(.ADDR_WIDTH(4), .FILL_OPCODE(4'b0111)) dut (
    .clk(clk), .reset(reset), .loadStart(loadStart), .nibbleIn(nibbleIn),
    .nibbleValid(nibbleValid), .loadLast(loadLast), .nibbleReady(nibbleReady),
    .addressIn(addressIn), .dataOut(dataOut), .cpuHold(cpuHold),
    .loadDone(loadDone), .loadError(loadError), .loadCount(loadCount)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // ---------------- reference model (behavioural) ----------------
  int         m_clear_left;   // sweep cycles still to run
  bit         m_loading;
  bit         m_pending;
  bit         m_err;
  bit         m_done;
  int         m_wr;
  int         m_cnt;
  logic [3:0] m_img [16];

  task automatic model_reset();
    m_clear_left = 16;
    m_loading = 0;
    m_pending = 0;
    m_err = 0;
    m_done = 0;
    m_wr = 0;
    m_cnt = 0;
    for (int i = 0; i < 16; i++) m_img[i] = 4'h7;
  endtask

  // Advance the model by one clock using the inputs held during that cycle
  task automatic model_tick();
    m_done = 0;
    if (m_clear_left > 0) begin
      m_img[16 - m_clear_left] = 4'h7;
      if (loadStart) m_pending = 1;
      m_clear_left--;
      if (m_clear_left == 0 && m_pending) begin
        m_loading = 1;
        m_pending = 0;
        m_wr = 0;
      end
    end else if (m_loading) begin
      if (loadStart) begin
        m_loading = 0; m_clear_left = 16; m_pending = 1; m_cnt = 0; m_err = 0;
      end else if (nibbleValid) begin
        m_img[m_wr] = nibbleIn;
        m_wr++;
        m_cnt++;
        if (loadLast || m_wr == 16) begin
          m_loading = 0;
          m_done = 1;
          if (!loadLast) m_err = 1;
        end
      end
    end else if (loadStart) begin
      m_clear_left = 16; m_pending = 1; m_cnt = 0; m_err = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    bit hold;
    hold = (m_clear_left > 0) || m_loading;
    chk("m_cpuHold", {31'd0, cpuHold}, {31'd0, hold});
    chk("m_nibbleReady", {31'd0, nibbleReady}, {31'd0, m_loading && !loadStart});
    chk("m_loadDone", {31'd0, loadDone}, {31'd0, m_done});
    chk("m_loadError", {31'd0, loadError}, {31'd0, m_err});
    chk("m_loadCount", {27'd0, loadCount}, m_cnt);
    chk("m_dataOut", {28'd0, dataOut}, {28'd0, hold ? 4'h7 : m_img[addressIn]});
  endtask

  // One clock: retire the previous cycle into the model, drive new inputs,
  // compare mid-cycle. Explicit checks after a call see this cycle's outputs.
  task automatic step(input logic ls, input logic nv, input logic [3:0] nib,
                      input logic last, input logic [3:0] addr);
    @(posedge clk);
    if (!reset) model_tick();
    @(negedge clk);
    loadStart = ls; nibbleValid = nv; nibbleIn = nib; loadLast = last; addressIn = addr;
    #1;
    compare_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
  endtask

  task automatic do_reset();
    loadStart = 0; nibbleValid = 0; loadLast = 0;
    reset = 1'b1;
    #1;
    chk("rst_cpuHold", {31'd0, cpuHold}, 32'd1);
    chk("rst_nibbleReady", {31'd0, nibbleReady}, 32'd0);
    chk("rst_loadDone", {31'd0, loadDone}, 32'd0);
    chk("rst_loadError", {31'd0, loadError}, 32'd0);
    chk("rst_loadCount", {27'd0, loadCount}, 32'd0);
    chk("rst_dataOut", {28'd0, dataOut}, 32'h7);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic readback(input string name, input logic [3:0] exp [16]);
    for (int a = 0; a < 16; a++) begin
      step(1'b0, 1'b0, 4'h0, 1'b0, a[3:0]);
      chk(name, {28'd0, dataOut}, {28'd0, exp[a]});
    end
  endtask

  // Directed load vectors: {opcode, loadLast, loadCount seen before accept}
  typedef struct {
    logic [3:0] nib;
    logic       last;
    logic [4:0] cnt_before;
  } vec_t;

  vec_t       vecs [8];
  logic [3:0] exp_img [16];

  initial begin
    vecs[0] = '{4'b0000, 1'b0, 5'd0};
    vecs[1] = '{4'b0001, 1'b0, 5'd1};
    vecs[2] = '{4'b1010, 1'b0, 5'd2};
    vecs[3] = '{4'b0010, 1'b0, 5'd3};
    vecs[4] = '{4'b1011, 1'b0, 5'd4};
    vecs[5] = '{4'b0010, 1'b0, 5'd5};
    vecs[6] = '{4'b1110, 1'b0, 5'd6};
    vecs[7] = '{4'b0010, 1'b1, 5'd7};

    #2;
    // --- power-up sweep ---
    do_reset();
    #1;
    chk("clr_hold_first", {31'd0, cpuHold}, 32'd1);
    for (int i = 0; i < 15; i++) begin
      idle(1);
      chk("clr_hold", {31'd0, cpuHold}, 32'd1);
    end
    idle(1);
    chk("clr_release", {31'd0, cpuHold}, 32'd0);
    for (int i = 0; i < 16; i++) exp_img[i] = 4'h7;
    readback("empty_read", exp_img);

    // --- contiguous and gapped loads of the same program ---
    for (int pass = 0; pass < 2; pass++) begin
      step(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
      idle(16);
      for (int i = 0; i < 8; i++) begin
        step(1'b0, 1'b1, vecs[i].nib, vecs[i].last, 4'h0);
        chk("load_ready", {31'd0, nibbleReady}, 32'd1);
        chk("load_count", {27'd0, loadCount}, {27'd0, vecs[i].cnt_before});
        if (pass == 1 && i < 7) begin
          step(1'b0, 1'b0, 4'hF, 1'b1, 4'h0);
          chk("gap_count", {27'd0, loadCount}, {27'd0, vecs[i].cnt_before} + 32'd1);
        end
      end
      idle(1);
      chk("done_pulse", {31'd0, loadDone}, 32'd1);
      chk("done_hold", {31'd0, cpuHold}, 32'd0);
      chk("done_count", {27'd0, loadCount}, 32'd8);
      idle(1);
      chk("done_once", {31'd0, loadDone}, 32'd0);
      for (int i = 0; i < 16; i++) exp_img[i] = (i < 8) ? vecs[i].nib : 4'h7;
      readback("prog_read", exp_img);
    end

    // --- overflow without loadLast ---
    step(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    idle(16);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4'b0001, 1'b0, 4'h0);
    idle(1);
    chk("ovf_error", {31'd0, loadError}, 32'd1);
    chk("ovf_count", {27'd0, loadCount}, 32'd16);
    chk("ovf_ready", {31'd0, nibbleReady}, 32'd0);
    chk("ovf_done", {31'd0, loadDone}, 32'd1);
    step(1'b0, 1'b1, 4'hF, 1'b0, 4'h0);
    chk("ovf_no17_ready", {31'd0, nibbleReady}, 32'd0);
    idle(1);
    chk("ovf_no17_count", {27'd0, loadCount}, 32'd16);
    for (int i = 0; i < 16; i++) exp_img[i] = 4'b0001;
    readback("ovf_read", exp_img);

    // --- reset in the middle of a load ---
    step(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    idle(16);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'hA, 1'b0, 4'h0);
    idle(1);
    chk("pre_rst_count", {27'd0, loadCount}, 32'd3);
    do_reset();
    idle(16);
    chk("post_rst_run", {31'd0, cpuHold}, 32'd0);
    for (int i = 0; i < 16; i++) exp_img[i] = 4'h7;
    readback("rst_read", exp_img);

    // --- loadStart collides with a valid nibble mid-load ---
    step(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    idle(16);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'h5, 1'b0, 4'h0);
    step(1'b1, 1'b1, 4'hF, 1'b0, 4'h0);
    chk("abort_ready", {31'd0, nibbleReady}, 32'd0);
    idle(1);
    chk("abort_count", {27'd0, loadCount}, 32'd0);
    chk("abort_hold", {31'd0, cpuHold}, 32'd1);
    idle(15);
    step(1'b0, 1'b1, 4'b1000, 1'b0, 4'h0);
    chk("reload_ready", {31'd0, nibbleReady}, 32'd1);
    step(1'b0, 1'b1, 4'b0010, 1'b1, 4'h0);
    idle(1);
    chk("reload_done", {31'd0, loadDone}, 32'd1);
    chk("reload_count", {27'd0, loadCount}, 32'd2);
    for (int i = 0; i < 16; i++) exp_img[i] = 4'h7;
    exp_img[0] = 4'b1000;
    exp_img[1] = 4'b0010;
    readback("reload_read", exp_img);

    // --- random traffic against the model ---
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 47) == 0), $urandom_range(0, 1) == 1,
           4'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0),
           4'($urandom_range(0, 15)));
      if ($urandom_range(0, 1499) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
